multiboot_ctrl: RTL and testbench
=================================

Name: multiboot_ctrl

Overview:
- Register-mapped front end for the Spartan-6 ICAP multiboot sequencer; sits directly upstream of it.
- CPU-side byte writes load a 24-bit SPI boot address, then a keyed write requests the reboot.
- Drives a stable spi_addr and a single-cycle MBT_REBOOT pulse.
- Holds off further requests while the downstream sequencer runs.

Parameters:
- ADDR_REG, 8'hFC, register number of the boot-address byte port.
- BOOT_REG, 8'hFD, register number of the boot command/status port.
- BOOT_KEY, 8'hB1, data value that must be written to BOOT_REG to trigger a reboot.
- DEFAULT_ADDR, 24'h098000, spi_addr value after reset.
- SETTLE_CYCLES, 2, cycles spi_addr is held frozen before the pulse (range 1..15).
- BUSY_CYCLES, 16, hold-off cycles after the pulse (range 1..255; at least the downstream sequence length).

Ports:
- CLK  in  1  single system clock; all logic is on its rising edge.
- MBT_RESET  in  1  synchronous, active-high reset.
- reg_addr  in  8  register number, valid with reg_wr/reg_rd.
- reg_wr  in  1  one-cycle write strobe.
- reg_rd  in  1  one-cycle read strobe.
- reg_din  in  8  write data.
- reg_dout  out  8  registered read data.
- reg_oe  out  1  high one cycle after a read hit on ADDR_REG or BOOT_REG.
- spi_addr  out  24  committed boot address; goes to the sequencer.
- MBT_REBOOT  out  1  one-cycle reboot request; goes to the sequencer.
- busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Reset values (sync, MBT_RESET=1 at an edge):
  - spi_addr=DEFAULT_ADDR, staging=24'h0, ptr=0.
  - MBT_REBOOT=0, busy=0, reg_dout=8'h00, reg_oe=0.
  - FSM=IDLE, counter=0.
- Reset mid-operation (SETTLE/FIRE/BUSY) aborts immediately to the reset values. No pulse is emitted after reset is sampled.
- Address load, IDLE only:
  - A write to ADDR_REG stores reg_din into staging byte[ptr]: ptr0 = bits 23:16, ptr1 = 15:8, ptr2 = 7:0.
  - ptr increments on each such write.
  - On the ptr2 write, the full 24-bit value is committed to spi_addr on the same edge and ptr wraps to 0.
  - spi_addr never shows a partially written value.
- Any write to BOOT_REG, any data, any state, resets ptr to 0. Staging is not cleared.
- Trigger: a write to BOOT_REG with reg_din==BOOT_KEY while IDLE moves the FSM to SETTLE.
  - The reboot uses the committed spi_addr; uncommitted staging bytes are discarded (ptr=0).
  - Non-key values are ignored (ptr reset only).
- FSM (registered, 2-bit):
  - IDLE: busy=0. Key write -> SETTLE, counter loaded with SETTLE_CYCLES-1.
  - SETTLE: counter decrements; -> FIRE when the counter is 0. Lasts exactly SETTLE_CYCLES cycles.
  - FIRE: MBT_REBOOT=1 for exactly this one cycle. -> BUSY, counter loaded with BUSY_CYCLES-1.
  - BUSY: counter decrements; -> IDLE when the counter is 0. Lasts exactly BUSY_CYCLES cycles.
- Latency: if the key write is sampled at edge t, busy rises after t and MBT_REBOOT is high in cycle t+SETTLE_CYCLES+1.
- In SETTLE/FIRE/BUSY:
  - ADDR_REG writes are ignored: staging, ptr and spi_addr are unchanged.
  - Key writes are ignored; no queueing.
  - BOOT_REG writes still reset ptr.
- Outputs MBT_REBOOT and busy are driven from flops, glitch-free.
- Reads, registered, one-cycle latency, any state:
  - ADDR_REG returns committed spi_addr byte[ptr] (same byte order as writes). ptr does not advance.
  - BOOT_REG returns {6'b0, busy, ptr!=0}.
  - A read to any other register gives reg_oe=0 and leaves reg_dout unchanged.
- Same-cycle reg_wr and reg_rd: the write takes effect at the edge; the read returns pre-edge contents.

Decomposition:
- multiboot_pkg holds:
  - ADDR_REG, BOOT_REG, BOOT_KEY;
  - DEFAULT_ADDR;
  - FSM state encodings (IDLE=0, SETTLE=1, FIRE=2, BUSY=3);
  - the byte-index constants for ptr.
- One sub-module, multiboot_addr_latch, holds staging, ptr, commit and readback mux.
  - Inputs: wr_en, rd sel, clear_ptr, lock.
  - The FSM, counter and pulse stay in the top.

Test Plan:
- Reset, no writes -> spi_addr=24'h098000, MBT_REBOOT never asserts, BOOT_REG read returns 8'h00 with reg_oe one cycle after reg_rd.
- Write ADDR_REG 8'h0A, 8'h40, 8'h00, then BOOT_REG 8'hB1 at edge t -> spi_addr changes only on the third write to 24'h0A4000; busy=1 from t+1; MBT_REBOOT high only in cycle t+3 (SETTLE_CYCLES=2); busy low after 16 BUSY cycles.
- Write ADDR_REG 8'h12, 8'h34 only, then BOOT_REG 8'hB1 -> pulse fires with prior committed spi_addr unchanged; BOOT_REG read afterwards shows ptr bit 0.
- BOOT_REG 8'h55 -> no state change, no pulse. Second BOOT_REG 8'hB1 and ADDR_REG writes during BUSY -> ignored; exactly one MBT_REBOOT pulse total; spi_addr unchanged.
- Assert MBT_RESET during SETTLE -> no MBT_REBOOT pulse, busy=0, spi_addr=24'h098000 next cycle.
- Read ADDR_REG after writing 8'hAA, 8'hBB, 8'hCC then one more 8'h11 -> reg_dout=8'hBB (ptr=1) while spi_addr stays 24'hAABBCC.

Source files
------------

// File: rtl/multiboot_pkg.sv
// multiboot_ctrl shared definitions: register map, reset address,
// FSM state encoding and byte-pointer constants.
package multiboot_pkg;

  localparam logic [7:0]  ADDR_REG     = 8'hFC;
  localparam logic [7:0]  BOOT_REG     = 8'hFD;
  localparam logic [7:0]  BOOT_KEY     = 8'hB1;
  localparam logic [23:0] DEFAULT_ADDR = 24'h098000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FIRE   = 2'd2,
    ST_BUSY   = 2'd3
  } mb_state_e;

  // ptr value -> address byte (most significant byte first)
  localparam logic [1:0] PTR_HI  = 2'd0;
  localparam logic [1:0] PTR_MID = 2'd1;
  localparam logic [1:0] PTR_LO  = 2'd2;

  function automatic logic [7:0] addr_byte(
    input logic [23:0] a,
    input logic [1:0]  p
  );
    logic [7:0] b;
    b = 8'h00;
    case (p)
      PTR_HI:  b = a[23:16];
      PTR_MID: b = a[15:8];
      PTR_LO:  b = a[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/multiboot_addr_latch.sv
// Boot-address staging: byte-wise load, atomic commit on the last byte,
// and the read-back mux.
// Ports: clk_i, rst_i (sync, high), wr_en_i/din_i (ADDR_REG write),
//   clear_ptr_i (BOOT_REG write), lock_i (sequence running),
//   rd_boot_i/busy_i (read select), spi_addr_o, ptr_o, rd_data_o.
module multiboot_addr_latch
  import multiboot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [7:0]  din_i,
  input  logic        clear_ptr_i,
  input  logic        lock_i,
  input  logic        rd_boot_i,
  input  logic        busy_i,
  output logic [23:0] spi_addr_o,
  output logic [1:0]  ptr_o,
  output logic [7:0]  rd_data_o
);

  logic [23:0] staging_q, staging_d;
  logic [23:0] addr_q, addr_d;
  logic [1:0]  ptr_q, ptr_d;

  always_comb begin
    staging_d = staging_q;
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    if (clear_ptr_i) begin
      ptr_d = PTR_HI;
    end else if (wr_en_i && !lock_i) begin
      case (ptr_q)
        PTR_HI:  staging_d[23:16] = din_i;
        PTR_MID: staging_d[15:8]  = din_i;
        PTR_LO:  staging_d[7:0]   = din_i;
        default: staging_d = staging_q;
      endcase
      if (ptr_q == PTR_LO) begin
        // last byte arrives with the write; commit all 24 bits at once
        addr_d = {staging_q[23:8], din_i};
        ptr_d  = PTR_HI;
      end else begin
        ptr_d = ptr_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      staging_q <= 24'h0;
      addr_q    <= DEFAULT_ADDR;
      ptr_q     <= PTR_HI;
    end else begin
      staging_q <= staging_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
    end
  end

  always_comb begin
    rd_data_o = addr_byte(addr_q, ptr_q);
    if (rd_boot_i) begin
      rd_data_o = {6'b0, busy_i, (ptr_q != PTR_HI)};
    end
  end

  assign spi_addr_o = addr_q;
  assign ptr_o      = ptr_q;

endmodule

// File: rtl/multiboot_ctrl.sv
// Register front end for the ICAP multiboot sequencer: loads the boot
// address, issues a keyed one-cycle MBT_REBOOT and holds off while busy.
// Ports: CLK, MBT_RESET (sync, high), reg_addr/reg_wr/reg_rd/reg_din,
//   reg_dout/reg_oe (registered read), spi_addr, MBT_REBOOT, busy.
module multiboot_ctrl
  import multiboot_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned BUSY_CYCLES   = 16
) (
  input  logic        CLK,
  input  logic        MBT_RESET,
  input  logic [7:0]  reg_addr,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  output logic        reg_oe,
  output logic [23:0] spi_addr,
  output logic        MBT_REBOOT,
  output logic        busy
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] BUSY_LD   = 8'(BUSY_CYCLES - 1);

  mb_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        reboot_q, reboot_d;
  logic        busy_q, busy_d;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d;

  logic        addr_wr, boot_wr, key_wr;
  logic        rd_addr, rd_boot, rd_hit;
  logic [7:0]  rd_data;
  logic [1:0]  ptr;

  assign addr_wr = reg_wr && (reg_addr == ADDR_REG);
  assign boot_wr = reg_wr && (reg_addr == BOOT_REG);
  assign key_wr  = boot_wr && (reg_din == BOOT_KEY);
  assign rd_addr = reg_rd && (reg_addr == ADDR_REG);
  assign rd_boot = reg_rd && (reg_addr == BOOT_REG);
  assign rd_hit  = rd_addr || rd_boot;

  multiboot_addr_latch u_latch (
    .clk_i       (CLK),
    .rst_i       (MBT_RESET),
    .wr_en_i     (addr_wr),
    .din_i       (reg_din),
    .clear_ptr_i (boot_wr),
    .lock_i      (state_q != ST_IDLE),
    .rd_boot_i   (rd_boot),
    .busy_i      (busy_q),
    .spi_addr_o  (spi_addr),
    .ptr_o       (ptr),
    .rd_data_o   (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (key_wr) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) state_d = ST_FIRE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_FIRE: begin
        state_d = ST_BUSY;
        cnt_d   = BUSY_LD;
      end
      ST_BUSY: begin
        if (cnt_q == 8'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    // outputs come straight from flops fed by the next state
    reboot_d = (state_d == ST_FIRE);
    busy_d   = (state_d != ST_IDLE);
  end

  always_comb begin
    oe_d   = rd_hit;
    dout_d = dout_q;
    if (rd_hit) dout_d = rd_data;
  end

  always_ff @(posedge CLK) begin
    if (MBT_RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      reboot_q <= 1'b0;
      busy_q   <= 1'b0;
      dout_q   <= 8'h00;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reboot_q <= reboot_d;
      busy_q   <= busy_d;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
    end
  end

  assign MBT_REBOOT = reboot_q;
  assign busy       = busy_q;
  assign reg_dout   = dout_q;
  assign reg_oe     = oe_q;

  logic unused_ptr;
  assign unused_ptr = ^ptr;

endmodule

// File: tb/tb_multiboot_ctrl.sv
// Self-checking bench for multiboot_ctrl: register loads, keyed
// reboot timing, hold-off, mid-sequence reset and read-back.
module tb_multiboot_ctrl;

  localparam logic [7:0] A_REG = 8'hFC;
  localparam logic [7:0] B_REG = 8'hFD;

  logic        CLK = 1'b0;
  logic        MBT_RESET;
  logic [7:0]  reg_addr;
  logic        reg_wr;
  logic        reg_rd;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout;
  logic        reg_oe;
  logic [23:0] spi_addr;
  logic        MBT_REBOOT;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;

  multiboot_ctrl dut (
    .CLK        (CLK),
    .MBT_RESET  (MBT_RESET),
    .reg_addr   (reg_addr),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_din    (reg_din),
    .reg_dout   (reg_dout),
    .reg_oe     (reg_oe),
    .spi_addr   (spi_addr),
    .MBT_REBOOT (MBT_REBOOT),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (MBT_REBOOT === 1'b1) pulses++;

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    reg_addr = a; reg_din = d; reg_wr = 1'b1;
    @(posedge CLK); #1;
    reg_wr = 1'b0;
  endtask

  task automatic do_rd(input logic [7:0] a, input logic [7:0] e);
    sb.push_back(e);
    @(negedge CLK);
    reg_addr = a; reg_rd = 1'b1;
    @(posedge CLK); #1;
    reg_rd = 1'b0;
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 100) begin tick(); k++; end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_idle: busy=%b still high after 100 cycles, want 0", busy);
    end
  endtask

  task automatic test_reset;
    MBT_RESET = 1'b1;
    tick(); tick();
    MBT_RESET = 1'b0;
    n_cmp++;
    if (spi_addr !== 24'h098000) begin
      n_bad++; $display("FAIL rst_spi: got %h want 098000", spi_addr);
    end
    n_cmp++;
    if (MBT_REBOOT !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_flags: reboot=%b busy=%b want 0 0", MBT_REBOOT, busy);
    end
    n_cmp++;
    if (reg_oe !== 1'b0 || reg_dout !== 8'h00) begin
      n_bad++; $display("FAIL rst_rd: oe=%b dout=%h want 0 00", reg_oe, reg_dout);
    end
    do_rd(B_REG, 8'h00);
    exp_b = sb.pop_front();
    n_cmp++;
    if (reg_oe !== 1'b1 || reg_dout !== exp_b) begin
      n_bad++; $display("FAIL rst_boot_rd: oe=%b dout=%h want 1 %h", reg_oe, reg_dout, exp_b);
    end
    tick();
    n_cmp++;
    if (reg_oe !== 1'b0) begin
      n_bad++; $display("FAIL rst_oe_drop: oe=%b want 0", reg_oe);
    end
    tick(); tick();
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL rst_no_pulse: pulses=%0d want 0", pulses);
    end
  endtask

  task automatic test_load_fire;
    int p0;
    do_wr(A_REG, 8'h0A);
    do_wr(A_REG, 8'h40);
    n_cmp++;
    if (spi_addr !== 24'h098000) begin
      n_bad++; $display("FAIL load_partial: spi=%h want 098000", spi_addr);
    end
    do_wr(A_REG, 8'h00);
    n_cmp++;
    if (spi_addr !== 24'h0A4000) begin
      n_bad++; $display("FAIL load_commit: spi=%h want 0a4000", spi_addr);
    end
    p0 = pulses;
    do_wr(B_REG, 8'hB1);
    n_cmp++;
    if (busy !== 1'b1 || MBT_REBOOT !== 1'b0) begin
      n_bad++; $display("FAIL fire_t1: busy=%b reboot=%b want 1 0", busy, MBT_REBOOT);
    end
    tick();
    n_cmp++;
    if (MBT_REBOOT !== 1'b0) begin
      n_bad++; $display("FAIL fire_t2: reboot=%b want 0", MBT_REBOOT);
    end
    tick();
    n_cmp++;
    if (MBT_REBOOT !== 1'b1 || spi_addr !== 24'h0A4000) begin
      n_bad++; $display("FAIL fire_t3: reboot=%b spi=%h want 1 0a4000", MBT_REBOOT, spi_addr);
    end
    tick();
    n_cmp++;
    if (MBT_REBOOT !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL fire_after: reboot=%b busy=%b want 0 1", MBT_REBOOT, busy);
    end
    for (int i = 0; i < 15; i++) tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL busy_last: busy=%b want 1", busy);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_end: busy=%b want 0", busy);
    end
    n_cmp++;
    if (pulses - p0 !== 1) begin
      n_bad++; $display("FAIL fire_count: pulses=%0d want 1", pulses - p0);
    end
  endtask

  task automatic test_partial;
    int p0;
    do_wr(A_REG, 8'h12);
    do_wr(A_REG, 8'h34);
    do_rd(B_REG, 8'h01);
    exp_b = sb.pop_front();
    n_cmp++;
    if (reg_oe !== 1'b1 || reg_dout !== exp_b) begin
      n_bad++; $display("FAIL part_ptr: dout=%h want %h", reg_dout, exp_b);
    end
    p0 = pulses;
    do_wr(B_REG, 8'hB1);
    do_rd(B_REG, 8'h02);
    exp_b = sb.pop_front();
    n_cmp++;
    if (reg_dout !== exp_b) begin
      n_bad++; $display("FAIL part_busy_rd: dout=%h want %h", reg_dout, exp_b);
    end
    wait_idle();
    n_cmp++;
    if (pulses - p0 !== 1 || spi_addr !== 24'h0A4000) begin
      n_bad++;
      $display("FAIL part_fire: pulses=%0d spi=%h want 1 0a4000", pulses - p0, spi_addr);
    end
    do_rd(B_REG, 8'h00);
    exp_b = sb.pop_front();
    n_cmp++;
    if (reg_dout !== exp_b) begin
      n_bad++; $display("FAIL part_after: dout=%h want %h", reg_dout, exp_b);
    end
  endtask

  task automatic test_ignored;
    int p0;
    p0 = pulses;
    do_wr(B_REG, 8'h55);
    tick(); tick(); tick(); tick();
    n_cmp++;
    if (busy !== 1'b0 || pulses !== p0) begin
      n_bad++; $display("FAIL nonkey: busy=%b pulses=%0d want 0 %0d", busy, pulses, p0);
    end
    do_wr(B_REG, 8'hB1);
    tick(); tick(); tick(); tick();
    do_wr(B_REG, 8'hB1);
    do_wr(A_REG, 8'h77);
    do_wr(A_REG, 8'h88);
    do_wr(A_REG, 8'h99);
    do_rd(B_REG, 8'h02);
    exp_b = sb.pop_front();
    n_cmp++;
    if (reg_dout !== exp_b || spi_addr !== 24'h0A4000) begin
      n_bad++;
      $display("FAIL busy_wr: dout=%h spi=%h want %h 0a4000", reg_dout, spi_addr, exp_b);
    end
    wait_idle();
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (pulses - p0 !== 1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL no_queue: pulses=%0d busy=%b want 1 0", pulses - p0, busy);
    end
  endtask

  task automatic test_reset_mid;
    int p0;
    p0 = pulses;
    do_wr(B_REG, 8'hB1);
    @(negedge CLK);
    MBT_RESET = 1'b1;
    tick();
    MBT_RESET = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || MBT_REBOOT !== 1'b0 || spi_addr !== 24'h098000) begin
      n_bad++;
      $display("FAIL mid_rst: busy=%b reboot=%b spi=%h want 0 0 098000",
               busy, MBT_REBOOT, spi_addr);
    end
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (pulses !== p0) begin
      n_bad++; $display("FAIL mid_rst_pulse: pulses=%0d want %0d", pulses, p0);
    end
  endtask

  task automatic test_readback;
    do_wr(A_REG, 8'hAA);
    do_wr(A_REG, 8'hBB);
    do_wr(A_REG, 8'hCC);
    do_wr(A_REG, 8'h11);
    do_rd(A_REG, 8'hBB);
    exp_b = sb.pop_front();
    n_cmp++;
    if (reg_oe !== 1'b1 || reg_dout !== exp_b || spi_addr !== 24'hAABBCC) begin
      n_bad++;
      $display("FAIL readback: dout=%h spi=%h want %h aabbcc", reg_dout, spi_addr, exp_b);
    end
    do_rd(A_REG, 8'hBB);
    exp_b = sb.pop_front();
    n_cmp++;
    if (reg_dout !== exp_b) begin
      n_bad++; $display("FAIL rd_no_adv: dout=%h want %h", reg_dout, exp_b);
    end
    do_rd(8'h10, 8'hBB);
    exp_b = sb.pop_front();
    n_cmp++;
    if (reg_oe !== 1'b0 || reg_dout !== exp_b) begin
      n_bad++; $display("FAIL rd_other: oe=%b dout=%h want 0 %h", reg_oe, reg_dout, exp_b);
    end
  endtask

  task automatic test_back_to_back;
    sb.push_back(8'h01);
    @(negedge CLK);
    reg_addr = B_REG; reg_din = 8'h55; reg_wr = 1'b1; reg_rd = 1'b1;
    tick();
    reg_wr = 1'b0; reg_rd = 1'b0;
    exp_b = sb.pop_front();
    n_cmp++;
    if (reg_oe !== 1'b1 || reg_dout !== exp_b) begin
      n_bad++; $display("FAIL wr_rd_same: dout=%h want %h", reg_dout, exp_b);
    end
    do_rd(B_REG, 8'h00);
    exp_b = sb.pop_front();
    n_cmp++;
    if (reg_dout !== exp_b) begin
      n_bad++; $display("FAIL wr_rd_after: dout=%h want %h", reg_dout, exp_b);
    end
    do_rd(A_REG, 8'hAA);
    exp_b = sb.pop_front();
    n_cmp++;
    if (reg_dout !== exp_b) begin
      n_bad++; $display("FAIL rd_hi_byte: dout=%h want %h", reg_dout, exp_b);
    end
  endtask

  initial begin
    MBT_RESET = 1'b1;
    reg_addr  = 8'h00;
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    reg_din   = 8'h00;
    test_reset();
    test_load_fire();
    test_partial();
    test_ignored();
    test_reset_mid();
    test_readback();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
